tinyml_source_common_sdp_ram_be_clr: RTL

//  Single-clock simple dual-port RAM: one write port and one read port.

---
 rtl/tinyml_source_common_sdp_ram_be_clr.sv | 138 +++++++++++++
 1 files changed

// File: rtl/tinyml_source_common_sdp_ram_be_clr.sv
// Simple dual-port RAM: one write port, one read port, single clock.
// Byte-enable writes, rvalid tracking pipeline, optional same-edge
// read/write bypass and a clear sequencer that fills the array with
// CLEAR_VALUE after reset or on clr_req.
module tinyml_source_common_sdp_ram_be_clr #(
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    BYTE_WIDTH     = 8,
    parameter int                    ADDR_WIDTH     = 9,
    parameter string                 OUTPUT_REG     = "TRUE",
    parameter string                 RW_BYPASS      = "TRUE",
    parameter string                 CLEAR_ON_RESET = "TRUE",
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic                             clr_req,
    output logic                             clr_busy,
    input  logic                             we,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] wbe,
    input  logic [ADDR_WIDTH-1:0]            waddr,
    input  logic [DATA_WIDTH-1:0]            wdata,
    input  logic                             re,
    input  logic [ADDR_WIDTH-1:0]            raddr,
    output logic [DATA_WIDTH-1:0]            rdata,
    output logic                             rvalid
);
    localparam int NUM_BYTES = DATA_WIDTH / BYTE_WIDTH;
    localparam int DEPTH     = 2 ** ADDR_WIDTH;
    localparam int STAGES    = (OUTPUT_REG == "TRUE") ? 2 : 1;
    localparam bit BYPASS    = (RW_BYPASS == "TRUE");
    localparam bit CLR_RST   = (CLEAR_ON_RESET == "TRUE");

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    logic [0:0]            state;
    logic [ADDR_WIDTH-1:0] cnt;
    logic                  clearing;
    logic                  rd_go;
    logic                  hit;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_word;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [NUM_BYTES-1:0]  wbe_q;
    logic                  hit_q;
    logic [DATA_WIDTH-1:0] rd_merged;
    logic [STAGES:1]       vld_pipe;

    assign clearing = (state == ST_CLEAR);
    assign clr_busy = clearing;
    // user traffic is only accepted while the sweep is not running
    assign rd_go    = re & ~clearing;
    assign hit      = rd_go & we & (raddr == waddr);
    assign rvalid   = vld_pipe[STAGES];

    // clear sequencer: IDLE <-> CLEAR, one address per cycle, DEPTH cycles
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= CLR_RST ? ST_CLEAR : ST_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (clr_req) begin
                        state <= ST_CLEAR;
                        cnt   <= '0;
                    end
                end
                ST_CLEAR: begin
                    cnt <= cnt + 1'b1;
                    if (&cnt) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // array write port: sweep has priority, user writes are byte-masked
    always_ff @(posedge clk) begin
        if (clearing) begin
            mem[cnt] <= CLEAR_VALUE;
        end else if (we) begin
            for (int i = 0; i < NUM_BYTES; i++) begin
                if (wbe[i]) mem[waddr][i*BYTE_WIDTH +: BYTE_WIDTH] <= wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    // registered, re-gated array read plus the write-side copies the bypass needs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_word <= '0;
            wdata_q <= '0;
            wbe_q   <= '0;
            hit_q   <= 1'b0;
        end else if (rd_go) begin
            rd_word <= mem[raddr];
            wdata_q <= wdata;
            wbe_q   <= wbe;
            hit_q   <= hit;
        end
    end

    // bypass merge after the read register; old bytes survive where wbe was 0
    always_comb begin
        rd_merged = rd_word;
        if (BYPASS && hit_q) begin
            for (int i = 0; i < NUM_BYTES; i++) begin
                if (wbe_q[i]) rd_merged[i*BYTE_WIDTH +: BYTE_WIDTH] = wdata_q[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    // read-valid shift register, one bit per read latency stage
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[1] <= rd_go;
            for (int i = 2; i <= STAGES; i++) vld_pipe[i] <= vld_pipe[i-1];
        end
    end

    generate
        if (STAGES == 2) begin : g_oreg
            logic [DATA_WIDTH-1:0] rdata_q;
            // output register only loads on a completing read so rdata holds
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn)            rdata_q <= '0;
                else if (vld_pipe[1]) rdata_q <= rd_merged;
            end
            assign rdata = rdata_q;
        end else begin : g_noreg
            assign rdata = rd_merged;
        end
    endgenerate
endmodule
